// File: rtl/nf_reg_file_mp.sv
// Multi-port register file: two combinational read ports with write-through forwarding,
// one write port, a sequenced full-array clear and a registered debug read port.
module nf_reg_file_mp #(
  parameter int  XLEN     = 32,
  parameter int  REG_N    = 32,
  parameter int  ZERO_REG = 1,
  localparam int AW       = $clog2(REG_N)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   ra1_i,
  output logic [XLEN-1:0] rd1_o,
  input  logic [AW-1:0]   ra2_i,
  output logic [XLEN-1:0] rd2_o,
  input  logic [AW-1:0]   wa3_i,
  input  logic [XLEN-1:0] wd3_i,
  input  logic            we3_i,
  input  logic            clr_req_i,
  output logic            busy_o,
  input  logic            dbg_req_i,
  input  logic [AW-1:0]   dbg_ra_i,
  output logic [XLEN-1:0] dbg_rd_o,
  output logic            dbg_vld_o
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            dbg_vld_q;
  logic [XLEN-1:0] dbg_rd_q;
  logic [XLEN-1:0] regs [REG_N];

  logic idle;
  logic wr_ok;

  // An address is backed by storage only if in range and not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < REG_N) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign idle  = (state_q == IDLE);
  assign wr_ok = idle && we3_i && addr_ok(wa3_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == AW'(REG_N - 1)) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    endcase
  end

  assign busy_o = (state_q == CLEAR);

  // Each register owns its write enable; the clear sweep takes priority over user writes.
  generate
    for (genvar gi = 0; gi < REG_N; gi++) begin : gen_reg
      logic            wen;
      logic [XLEN-1:0] data_q;

      assign wen = busy_o ? (clr_cnt_q == AW'(gi)) : (wr_ok && (wa3_i == AW'(gi)));

      always_ff @(posedge clk_i) begin
        if (wen) data_q <= busy_o ? '0 : wd3_i;
      end

      assign regs[gi] = data_q;
    end
  endgenerate

  always_comb begin
    rd1_o = '0;
    if (idle && addr_ok(ra1_i)) begin
      rd1_o = (wr_ok && (wa3_i == ra1_i)) ? wd3_i : regs[ra1_i];
    end
  end

  always_comb begin
    rd2_o = '0;
    if (idle && addr_ok(ra2_i)) begin
      rd2_o = (wr_ok && (wa3_i == ra2_i)) ? wd3_i : regs[ra2_i];
    end
  end

  // Debug read returns the stored value as of the request cycle, never the forwarded write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dbg_vld_q <= 1'b0;
      dbg_rd_q  <= '0;
    end else begin
      dbg_vld_q <= idle && dbg_req_i;
      if (idle && dbg_req_i) begin
        dbg_rd_q <= addr_ok(dbg_ra_i) ? regs[dbg_ra_i] : '0;
      end
    end
  end

  assign dbg_vld_o = dbg_vld_q;
  assign dbg_rd_o  = dbg_rd_q;

endmodule
